// File: rtl/halt_reporter_if.sv
// ----------------------------------------------------------------------------
// halt_reporter_if
//
// Groups the halt-report signals between the CPU/debug side and the
// halt_reporter UART transmitter.
//
//   halt     CPU halted flag, synchronous to clk
//   pc       16-bit CPU program counter, sampled on an accepted halt edge
//   tx       serial 8N1 output, idle high
//   busy     high while a report is in flight
//   overrun  one-cycle pulse when a halt edge arrives while busy
//
// Modports:
//   master  drives halt/pc, observes tx/busy/overrun (CPU side, testbench)
//   slave   the reporter itself
// ----------------------------------------------------------------------------
interface halt_reporter_if;
    logic        halt;
    logic [15:0] pc;
    logic        tx;
    logic        busy;
    logic        overrun;

    modport master (
        output halt,
        output pc,
        input  tx,
        input  busy,
        input  overrun
    );

    modport slave (
        input  halt,
        input  pc,
        output tx,
        output busy,
        output overrun
    );
endinterface : halt_reporter_if

// File: rtl/halt_reporter.sv
// ----------------------------------------------------------------------------
// halt_reporter
//
// UART transmit side of the debug link. On every rising edge of halt that
// arrives while idle, the program counter is captured and a 6-byte ASCII
// report is sent over an 8N1 line: 'H', four uppercase hex digits of the PC
// (most significant first), then '\n'. Bytes are sent back to back with no
// idle gap between a stop bit and the next start bit.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (2..65535)
//
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous, active-high reset
//   bus      halt_reporter_if.slave
//              halt    (in)  CPU halted flag
//              pc      (in)  program counter
//              tx      (out) serial output, idle high
//              busy    (out) report in flight
//              overrun (out) one-cycle pulse for a dropped halt edge
// ----------------------------------------------------------------------------
module halt_reporter #(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic              clk,
    input  logic              reset,
    halt_reporter_if.slave    bus
);

    localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BYTE = 3'd5;
    localparam logic [2:0]  LAST_BIT  = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Uppercase ASCII hex digit.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    // Character at position idx of the report for program counter p.
    function automatic logic [7:0] report_byte(input logic [2:0] idx,
                                               input logic [15:0] p);
        logic [7:0] c;
        c = 8'h0A;
        case (idx)
            3'd0:    c = 8'h48;
            3'd1:    c = hex_char(p[15:12]);
            3'd2:    c = hex_char(p[11:8]);
            3'd3:    c = hex_char(p[7:4]);
            3'd4:    c = hex_char(p[3:0]);
            default: c = 8'h0A;
        endcase
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t      state_q,    state_d;
    logic [15:0] bit_cnt_q,  bit_cnt_d;
    logic [2:0]  bit_idx_q,  bit_idx_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic [15:0] pc_q,       pc_d;
    logic        tx_q,       tx_d;
    logic        busy_q,     busy_d;
    logic        overrun_q,  overrun_d;
    logic        halt_q;

    logic        halt_rise;
    logic        accept;
    logic        bit_done;
    logic [7:0]  cur_byte;

    assign halt_rise = bus.halt & ~halt_q;
    // busy_q is the registered flag, so an edge on the final stop-bit cycle
    // still sees busy=1 and is dropped.
    assign accept    = halt_rise & ~busy_q;
    assign bit_done  = (bit_cnt_q == LAST_CNT);

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        pc_d       = pc_q;
        overrun_d  = halt_rise & busy_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = START;
                    bit_cnt_d  = '0;
                    bit_idx_d  = '0;
                    byte_idx_d = '0;
                    pc_d       = bus.pc;
                end
            end

            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 16'd1;
                end
            end

            DATA: begin
                if (bit_done) begin
                    bit_cnt_d = '0;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 16'd1;
                end
            end

            STOP: begin
                if (bit_done) begin
                    bit_cnt_d = '0;
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d = IDLE;
                    end else begin
                        // Next start bit follows the stop bit directly.
                        state_d    = START;
                        bit_idx_d  = '0;
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 16'd1;
                end
            end

            default: state_d = IDLE;
        endcase

        // tx and busy are registered from the next state so the line level
        // changes on the same edge that enters each bit.
        cur_byte = report_byte(byte_idx_d, pc_d);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            pc_q       <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            pc_q       <= pc_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            halt_q     <= bus.halt;
        end
    end

    assign bus.tx      = tx_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = overrun_q;

endmodule : halt_reporter

// File: tb/tb_halt_reporter.sv
// ----------------------------------------------------------------------------
// tb_halt_reporter
//
// Directed bench for halt_reporter with CLKS_PER_BIT=4. A serial monitor
// decodes tx into a byte queue; a table of {pc, expected report bytes}
// drives the main loop, and hand-written sequences cover overrun, the
// final-busy-cycle edge, held halt and mid-frame reset.
// Inputs change on the falling edge; outputs are checked on the falling
// edge and decoded 2 time units after the rising edge.
// ----------------------------------------------------------------------------
module tb_halt_reporter;

    localparam int CPB          = 4;
    localparam int FRAME_CYCLES = 60 * CPB;

    logic clk;
    logic reset;

    halt_reporter_if bus ();

    halt_reporter #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------
    // Serial monitor
    // ------------------------------------------------------------------
    logic [7:0] rx_q [$];
    int         frame_err  = 0;
    int         ovr_cnt    = 0;
    int         ovr_double = 0;
    logic       ovr_prev   = 1'b0;
    logic       rx_active  = 1'b0;
    int         rx_cnt     = 0;
    logic [7:0] rx_shift   = 8'h00;

    always @(posedge clk) begin
        #2;
        if (reset) begin
            rx_active = 1'b0;
            ovr_prev  = 1'b0;
        end else begin
            if (bus.overrun) begin
                ovr_cnt++;
                if (ovr_prev) ovr_double++;
            end
            ovr_prev = bus.overrun;

            if (!rx_active) begin
                if (bus.tx == 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                end
            end else begin
                rx_cnt++;
                for (int k = 0; k < 8; k++) begin
                    if (rx_cnt == CPB * (k + 1) + CPB / 2) rx_shift[k] = bus.tx;
                end
                if (rx_cnt == 9 * CPB + CPB / 2) begin
                    if (bus.tx !== 1'b1) frame_err++;
                    rx_q.push_back(rx_shift);
                    rx_active = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Compare the decoded queue with a 6-byte report.
    task automatic check_bytes(input string name, input logic [47:0] exp);
        check({name, "_count"}, 32'(rx_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < rx_q.size())
                check($sformatf("%s_byte%0d", name, i), {24'h0, rx_q[i]},
                      {24'h0, exp[47 - 8 * i -: 8]});
        end
    endtask

    // From a falling edge where busy is already 1, count busy cycles
    // (bounded) until busy drops.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 4 * FRAME_CYCLES; i++) begin
            if (bus.busy !== 1'b1) break;
            n++;
            step();
        end
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [15:0] pc;
        logic [47:0] exp;
    } vec_t;

    vec_t vecs [5];

    int          nb;
    int          n;
    int          fe_base;
    int          ov_base;
    int          tx_low;
    int          busy_hi;
    int          ovr_hi;

    initial begin
        vecs[0] = '{16'h1A2F, 48'h48_31_41_32_46_0A};
        vecs[1] = '{16'h09F0, 48'h48_30_39_46_30_0A};
        vecs[2] = '{16'hFFFF, 48'h48_46_46_46_46_0A};
        vecs[3] = '{16'h0000, 48'h48_30_30_30_30_0A};
        vecs[4] = '{16'hBEEF, 48'h48_42_45_45_46_0A};

        reset    = 1'b1;
        bus.halt = 1'b0;
        bus.pc   = 16'h0000;

        // ---------------- reset ----------------
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("reset_tx_%0d", i),      {31'h0, bus.tx},      32'd1);
            check($sformatf("reset_busy_%0d", i),    {31'h0, bus.busy},    32'd0);
            check($sformatf("reset_overrun_%0d", i), {31'h0, bus.overrun}, 32'd0);
        end
        reset  = 1'b0;
        tx_low = 0; busy_hi = 0; ovr_hi = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.tx !== 1'b1)     tx_low++;
            if (bus.busy !== 1'b0)   busy_hi++;
            if (bus.overrun !== 1'b0) ovr_hi++;
        end
        check("idle_tx_low_cycles",  32'(tx_low),  32'd0);
        check("idle_busy_cycles",    32'(busy_hi), 32'd0);
        check("idle_overrun_cycles", 32'(ovr_hi),  32'd0);

        // ---------------- table-driven reports ----------------
        for (int v = 0; v < 5; v++) begin
            rx_q.delete();
            fe_base  = frame_err;
            bus.pc   = vecs[v].pc;
            bus.halt = 1'b1;
            step();
            check($sformatf("v%0d_start_tx", v),   {31'h0, bus.tx},   32'd0);
            check($sformatf("v%0d_start_busy", v), {31'h0, bus.busy}, 32'd1);
            bus.pc = ~vecs[v].pc;            // must not affect frame in flight
            count_busy(nb);
            check($sformatf("v%0d_busy_cycles", v), 32'(nb), 32'(FRAME_CYCLES));
            repeat (20) step();
            check_bytes($sformatf("v%0d", v), vecs[v].exp);
            check($sformatf("v%0d_framing", v), 32'(frame_err - fe_base), 32'd0);
            check($sformatf("v%0d_idle_tx", v), {31'h0, bus.tx}, 32'd1);
            bus.halt = 1'b0;
            repeat (3) step();
        end

        // ---------------- overrun mid-frame and on final busy cycle ----------------
        rx_q.delete();
        ov_base  = ovr_cnt;
        bus.pc   = 16'h1234;
        bus.halt = 1'b1;
        step(); n = 1;
        check("ovr_start_tx", {31'h0, bus.tx}, 32'd0);
        while (n < 50) begin step(); n++; end
        bus.halt = 1'b0;
        step(); n++;                         // n = 51
        bus.halt = 1'b1;
        step(); n++;                         // n = 52
        check("ovr_pulse_high", {31'h0, bus.overrun}, 32'd1);
        step(); n++;                         // n = 53
        check("ovr_pulse_low",  {31'h0, bus.overrun}, 32'd0);
        while (n < 200) begin step(); n++; end
        bus.halt = 1'b0;
        while (n < FRAME_CYCLES) begin step(); n++; end
        check("ovr_last_busy_cycle", {31'h0, bus.busy}, 32'd1);
        bus.halt = 1'b1;                     // edge on the final busy cycle
        step(); n++;
        check("ovr_final_busy_low", {31'h0, bus.busy},    32'd0);
        check("ovr_final_pulse",    {31'h0, bus.overrun}, 32'd1);
        step();
        check("ovr_final_pulse_low", {31'h0, bus.overrun}, 32'd0);
        repeat (20) step();
        check("ovr_no_second_frame", {31'h0, bus.busy}, 32'd0);
        check_bytes("ovr_frame", 48'h48_31_32_33_34_0A);
        check("ovr_pulse_total",  32'(ovr_cnt - ov_base), 32'd2);
        check("ovr_double_pulse", 32'(ovr_double),        32'd0);

        // ---------------- edge one cycle after busy drops ----------------
        bus.halt = 1'b0;
        repeat (3) step();
        rx_q.delete();
        bus.pc   = 16'hC0DE;
        bus.halt = 1'b1;
        step(); n = 1;
        while (n < 200) begin step(); n++; end
        bus.halt = 1'b0;
        while (n < FRAME_CYCLES) begin step(); n++; end
        check("rs_last_busy", {31'h0, bus.busy}, 32'd1);
        step();
        check("rs_busy_low", {31'h0, bus.busy}, 32'd0);
        check_bytes("rs_first", 48'h48_43_30_44_45_0A);
        rx_q.delete();
        bus.halt = 1'b1;
        step();
        check("rs_restart_tx",   {31'h0, bus.tx},   32'd0);
        check("rs_restart_busy", {31'h0, bus.busy}, 32'd1);
        count_busy(nb);
        check("rs_busy_cycles", 32'(nb), 32'(FRAME_CYCLES));
        repeat (10) step();
        check_bytes("rs_second", 48'h48_43_30_44_45_0A);
        bus.halt = 1'b0;
        repeat (3) step();

        // ---------------- held halt: one report only ----------------
        rx_q.delete();
        bus.pc   = 16'h8000;
        bus.halt = 1'b1;
        busy_hi  = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (bus.busy === 1'b1) busy_hi++;
        end
        check("held_busy_cycles", 32'(busy_hi), 32'(FRAME_CYCLES));
        check_bytes("held", 48'h48_38_30_30_30_0A);
        check("held_idle_tx", {31'h0, bus.tx}, 32'd1);

        // ---------------- mid-frame reset with halt held ----------------
        bus.halt = 1'b0;
        repeat (3) step();
        rx_q.delete();
        bus.pc   = 16'h7E57;
        bus.halt = 1'b1;
        step(); n = 1;
        while (n < 100) begin step(); n++; end
        check("mr_busy_before", {31'h0, bus.busy}, 32'd1);
        reset  = 1'b1;
        bus.pc = 16'hA5C3;
        step();
        check("mr_reset_tx",      {31'h0, bus.tx},      32'd1);
        check("mr_reset_busy",    {31'h0, bus.busy},    32'd0);
        check("mr_reset_overrun", {31'h0, bus.overrun}, 32'd0);
        reset = 1'b0;
        rx_q.delete();
        fe_base = frame_err;
        step();
        check("mr_restart_tx",   {31'h0, bus.tx},   32'd0);
        check("mr_restart_busy", {31'h0, bus.busy}, 32'd1);
        count_busy(nb);
        check("mr_busy_cycles", 32'(nb), 32'(FRAME_CYCLES));
        repeat (10) step();
        check_bytes("mr", 48'h48_41_35_43_33_0A);
        check("mr_framing", 32'(frame_err - fe_base), 32'd0);
        bus.halt = 1'b0;
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_halt_reporter

// File: doc/halt_reporter.md
# halt_reporter

UART transmit side of the debug link whose receive side accepts the 's'/'p' halt commands. On each rising edge of `halt`, the block captures the 16-bit CPU program counter. It then sends a fixed 6-byte ASCII report over an 8N1 serial line: 'H', four uppercase hex digits of the PC (most significant first), then '\n'. It sits in the clk domain next to the command receiver and drives the board's UART TX pin.

## Interface

- `CLKS_PER_BIT`, default 217: clk cycles per serial bit (25 MHz / 115200). Legal range 2..65535.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `halt`  in  1  CPU halted flag, already synchronous to clk.
- `pc`  in  16  CPU program counter; sampled only on an accepted halt edge.
- `tx`  out  1  serial output, idle high.
- `busy`  out  1  high while a report is in flight.
- `overrun`  out  1  one-cycle pulse when a halt edge is dropped.

## Operation

- Edge detect: `halt_q` is a registered copy of `halt` (reset value 0). edge = `halt` & ~`halt_q`.
- Accepted edge: edge and `busy`==0 (registered value). On acceptance:
  - latch `pc`;
  - load byte index 0;
  - enter START.
- Dropped edge: edge and `busy`==1. No effect on the frame in flight; `overrun`=1 for exactly the next cycle.
- Byte sequence, index 0..5: 0x48 ('H'), hex(pc[15:12]), hex(pc[11:8]), hex(pc[7:4]), hex(pc[3:0]), 0x0A.
  - hex(n) = 0x30+n for n<10, 0x37+n for n>=10 (uppercase).
- Bit FSM states:
  - IDLE: tx=1.
  - START: tx=0.
  - DATA: bits 0..7, LSB first.
  - STOP: tx=1.
  - Each bit lasts exactly CLKS_PER_BIT cycles, timed by a bit counter that counts 0..CLKS_PER_BIT-1.
- Transitions:
  - IDLE->START on an accepted edge.
  - START->DATA.
  - DATA->DATA (bit index+1) until bit 7 completes, then STOP.
  - STOP->START with index+1 if index<5. STOP->IDLE if index==5.
- There is no idle gap between bytes: the next start bit directly follows the previous stop bit.
- `busy`=1 from the accept edge until the end of the last stop bit.
- Reset is applied at any time, including mid-frame. At the next edge:
  - tx=1, busy=0, overrun=0;
  - FSM returns to IDLE and all counters clear;
  - halt_q=0, so a `halt` held high through reset release produces a new report.

## Timing

- Reset values: tx=1, busy=0, overrun=0, halt_q=0, state IDLE.
- Frame start latency: the first clock edge at which `halt`=1 with halt_q=0 and busy=0 registers tx=0 and busy=1. This is 1 cycle after `halt` rises.
- Per byte: 10*CLKS_PER_BIT cycles. Full report: 60*CLKS_PER_BIT cycles from the accept edge to the edge that registers busy=0.
- Edge on the same cycle as the final stop-bit cycle: busy is still 1, so the edge is dropped and overrun pulses. A new report requires a fresh rising edge after busy=0.
- `halt` held high for any duration produces one report only. Low-going edges are ignored.
- `pc` changes after acceptance do not affect the frame in flight.
- `overrun` is registered and is never high for 2 consecutive cycles from a single edge.

## Test plan

- Reset check: assert reset 3 cycles with `halt`=0 -> tx=1, busy=0, overrun=0 on every cycle; tx stays 1 for 100 cycles after release.
- Basic report, CLKS_PER_BIT=4, pc=0x1A2F:
  - raise `halt` -> serial decode yields bytes 0x48,0x31,0x41,0x32,0x46,0x0A;
  - tx is low exactly 1 cycle after `halt` rises;
  - busy is high for exactly 240 cycles.
- Hex boundaries: pc=0x09F0 -> digits '0','9','F','0' (0x30,0x39,0x46,0x30); pc=0xFFFF -> four 0x46 bytes.
- Overrun, CLKS_PER_BIT=4:
  - pulse `halt` low then high 50 cycles into a frame -> overrun=1 for 1 cycle, frame bytes unchanged, no second frame;
  - an edge on the final busy cycle is also dropped;
  - an edge 1 cycle after busy=0 starts a new frame.
- Held halt: keep `halt`=1 for 1000 cycles with CLKS_PER_BIT=4 -> exactly one report, then tx=1 idle.
- Mid-frame reset:
  - assert reset at cycle 100 of a frame with `halt` held high -> tx=1 and busy=0 on the next edge;
  - after release, a new full report with the current `pc` begins 1 cycle later.
